// File: rtl/bist_misr_analyzer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bist_pkg
// Purpose : Shared definitions for the BIST response analyzer: FSM state
//           encoding, default MISR polynomial/seed, and the single-step MISR
//           update function (Galois form, left shift, feedback on MSB).
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package bist_pkg;

  localparam int MISR_W = 16;

  // x^16 + x^12 + x^5 + 1 in Galois feedback-mask form
  localparam logic [MISR_W-1:0] POLY_DEFAULT = 16'h1021;
  localparam logic [MISR_W-1:0] SEED_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPACT = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  // One MISR step: shift left, fold the outgoing MSB back through the
  // polynomial mask, then XOR in the response word.
  function automatic logic [MISR_W-1:0] misr_next(
    input logic [MISR_W-1:0] sig,
    input logic [MISR_W-1:0] data,
    input logic [MISR_W-1:0] poly
  );
    return {sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? poly : '0) ^ data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bist_misr_analyzer_misr_core.sv
`default_nettype none
// ============================================================================
// Module  : misr_core
// Purpose : W-bit multiple-input signature register. A load request reloads
//           the seed and wins over a shift; a shift folds i_data into the
//           signature using the Galois feedback mask POLY.
// Ports   : clk     - system clock, rising edge
//           rst_n   - asynchronous active-low reset (register -> SEED)
//           i_load  - reload SEED this cycle
//           i_shift - compact i_data this cycle
//           i_data  - response word
//           o_sig   - current signature (registered)
// Rev     : 1.0  initial release
// ============================================================================
module misr_core
  import bist_pkg::*;
#(
  parameter int            W    = 16,
  parameter logic [W-1:0]  POLY = POLY_DEFAULT[W-1:0],
  parameter logic [W-1:0]  SEED = SEED_DEFAULT[W-1:0]
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_sig
);

  logic [W-1:0] sig_q;
  logic [W-1:0] sig_d;
  logic [W-1:0] w_step;

  // The package helper is fixed at the default width; other widths use the
  // same equation written out generically.
  if (W == MISR_W) begin : g_pkg_step
    assign w_step = misr_next(sig_q, i_data, POLY);
  end else begin : g_generic_step
    assign w_step = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ i_data;
  end

  always_comb begin
    sig_d = sig_q;
    if (i_load) begin
      sig_d = SEED;
    end else if (i_shift) begin
      sig_d = w_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign o_sig = sig_q;

endmodule
`default_nettype wire

// File: rtl/bist_misr_analyzer.sv
`default_nettype none
// ============================================================================
// Module  : bist_misr_analyzer
// Purpose : Response analyzer of the BIST loop. Compacts CUT responses into a
//           MISR while EN is high, counts compacted vectors (saturating), and
//           on FINISH compares signature and count against golden values,
//           holding a sticky PASS/FAIL verdict until the next START rise.
// Ports   : CLK       - system clock, rising edge
//           RESET     - asynchronous active-low reset
//           START     - run request level; rising edge opens a run
//           EN        - compact DATA_IN this cycle
//           FINISH    - closes the run
//           DATA_IN   - CUT response word (W bits)
//           SIGNATURE - current MISR contents
//           VEC_COUNT - vectors compacted in current/last run
//           DONE      - verdict valid
//           PASS      - signature and count both matched
//           FAIL      - verdict valid and not PASS
// Rev     : 1.0  initial release
// ============================================================================
module bist_misr_analyzer
  import bist_pkg::*;
#(
  parameter int            W         = 16,
  parameter logic [W-1:0]  POLY      = POLY_DEFAULT[W-1:0],
  parameter logic [W-1:0]  SEED      = SEED_DEFAULT[W-1:0],
  parameter logic [W-1:0]  GOLDEN    = '0,
  parameter int            CW        = 11,
  parameter logic [CW-1:0] EXP_COUNT = 990
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          START,
  input  logic          EN,
  input  logic          FINISH,
  input  logic [W-1:0]  DATA_IN,
  output logic [W-1:0]  SIGNATURE,
  output logic [CW-1:0] VEC_COUNT,
  output logic          DONE,
  output logic          PASS,
  output logic          FAIL
);

  state_e        state_q, state_d;
  logic          start_q;
  logic [CW-1:0] count_q, count_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          fail_q, fail_d;

  logic          w_start_rise;
  logic          w_load;
  logic          w_shift;
  logic          w_match;
  logic [W-1:0]  w_sig;

  // start_q resets to 1 so a START held high through reset release is not
  // mistaken for a fresh rising edge.
  assign w_start_rise = START & ~start_q;
  assign w_match      = (w_sig == GOLDEN) && (count_q == EXP_COUNT);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    w_load  = 1'b0;
    w_shift = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_start_rise) begin
          state_d = S_COMPACT;
          w_load  = 1'b1;
          count_d = '0;
        end
      end

      S_COMPACT: begin
        if (w_start_rise) begin
          // Restart outranks both EN and FINISH in the same cycle.
          w_load  = 1'b1;
          count_d = '0;
        end else begin
          if (EN) begin
            w_shift = 1'b1;
            if (count_q != {CW{1'b1}}) begin
              count_d = count_q + 1'b1;
            end
          end
          if (FINISH) begin
            state_d = S_COMPARE;
          end
        end
      end

      S_COMPARE: begin
        pass_d  = w_match;
        fail_d  = ~w_match;
        done_d  = 1'b1;
        state_d = S_DONE;
      end

      S_DONE: begin
        if (w_start_rise) begin
          done_d  = 1'b0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          w_load  = 1'b1;
          count_d = '0;
          state_d = S_COMPACT;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      start_q <= 1'b1;
      count_q <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= START;
      count_q <= count_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  misr_core #(
    .W    (W),
    .POLY (POLY),
    .SEED (SEED)
  ) u_misr (
    .clk     (CLK),
    .rst_n   (RESET),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (DATA_IN),
    .o_sig   (w_sig)
  );

  assign SIGNATURE = w_sig;
  assign VEC_COUNT = count_q;
  assign DONE      = done_q;
  assign PASS      = pass_q;
  assign FAIL      = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_bist_misr_analyzer.sv
`default_nettype none
// ============================================================================
// Module  : tb_bist_misr_analyzer
// Purpose : Directed self-checking bench for bist_misr_analyzer, configured
//           with GOLDEN=0 and EXP_COUNT=5 so short all-zero runs pass.
// Rev     : 1.0  initial release
// ============================================================================
module tb_bist_misr_analyzer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic        EN;
  logic        FINISH;
  logic [15:0] DATA_IN;
  logic [15:0] SIGNATURE;
  logic [10:0] VEC_COUNT;
  logic        DONE;
  logic        PASS;
  logic        FAIL;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  bist_misr_analyzer #(
    .W         (16),
    .POLY      (16'h1021),
    .SEED      (16'h0000),
    .GOLDEN    (16'h0000),
    .CW        (11),
    .EXP_COUNT (11'd5)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .EN        (EN),
    .FINISH    (FINISH),
    .DATA_IN   (DATA_IN),
    .SIGNATURE (SIGNATURE),
    .VEC_COUNT (VEC_COUNT),
    .DONE      (DONE),
    .PASS      (PASS),
    .FAIL      (FAIL)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic open_run();
    START = 1'b0; EN = 1'b0; FINISH = 1'b0; DATA_IN = 16'h0000;
    step();
    START = 1'b1;
    step();
  endtask

  task automatic test_reset();
    RESET = 1'b0; START = 1'b1; EN = 1'b0; FINISH = 1'b0; DATA_IN = 16'h0000;
    repeat (3) step();
    checks++; if (SIGNATURE !== 16'h0000) begin errors++; $display("FAIL reset_sig got %h exp 0000", SIGNATURE); end
    checks++; if (VEC_COUNT !== 11'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", VEC_COUNT); end
    checks++; if ({DONE, PASS, FAIL} !== 3'b000) begin errors++; $display("FAIL reset_verdict got %b exp 000", {DONE, PASS, FAIL}); end
    // START still high after release: no run may open, EN/FINISH ignored in IDLE.
    RESET = 1'b1; EN = 1'b1; FINISH = 1'b1; DATA_IN = 16'h0001;
    repeat (5) step();
    checks++; if (SIGNATURE !== 16'h0000) begin errors++; $display("FAIL held_start_sig got %h exp 0000", SIGNATURE); end
    checks++; if (VEC_COUNT !== 11'd0) begin errors++; $display("FAIL held_start_count got %0d exp 0", VEC_COUNT); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL held_start_done got %b exp 0", DONE); end
    EN = 1'b0; FINISH = 1'b0; DATA_IN = 16'h0000;
  endtask

  task automatic test_zero_pass();
    open_run();
    EN = 1'b1; DATA_IN = 16'h0000;
    repeat (5) step();
    checks++; if (VEC_COUNT !== 11'd5) begin errors++; $display("FAIL zero_count got %0d exp 5", VEC_COUNT); end
    EN = 1'b0; FINISH = 1'b1;
    step();
    FINISH = 1'b0;
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL zero_done_early got %b exp 0", DONE); end
    // EN in COMPARE and DONE must not disturb the signature.
    EN = 1'b1; DATA_IN = 16'hFFFF;
    step(); step();
    checks++; if ({DONE, PASS, FAIL} !== 3'b110) begin errors++; $display("FAIL zero_verdict got %b exp 110", {DONE, PASS, FAIL}); end
    checks++; if (SIGNATURE !== 16'h0000) begin errors++; $display("FAIL zero_sig_held got %h exp 0000", SIGNATURE); end
    EN = 1'b0; DATA_IN = 16'h0000;
  endtask

  task automatic test_fail_flip();
    logic [15:0] data_seq [5];
    data_seq = '{16'h0000, 16'h0000, 16'h0004, 16'h0000, 16'h0000};
    open_run();
    checks++; if ({DONE, PASS, FAIL} !== 3'b000) begin errors++; $display("FAIL flip_clear got %b exp 000", {DONE, PASS, FAIL}); end
    EN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      DATA_IN = data_seq[i];
      step();
      if (i == 2) begin
        checks++; if (SIGNATURE !== 16'h0004) begin errors++; $display("FAIL flip_sig3 got %h exp 0004", SIGNATURE); end
      end
    end
    checks++; if (SIGNATURE !== 16'h0010) begin errors++; $display("FAIL flip_sig5 got %h exp 0010", SIGNATURE); end
    EN = 1'b0; FINISH = 1'b1; DATA_IN = 16'h0000;
    step();
    FINISH = 1'b0;
    step(); step();
    checks++; if ({DONE, PASS, FAIL} !== 3'b101) begin errors++; $display("FAIL flip_verdict got %b exp 101", {DONE, PASS, FAIL}); end
    // Verdict and signature held in DONE regardless of EN/FINISH.
    EN = 1'b1; FINISH = 1'b1; DATA_IN = 16'h0001;
    repeat (3) step();
    checks++; if (SIGNATURE !== 16'h0010) begin errors++; $display("FAIL flip_hold_sig got %h exp 0010", SIGNATURE); end
    checks++; if (VEC_COUNT !== 11'd5) begin errors++; $display("FAIL flip_hold_count got %0d exp 5", VEC_COUNT); end
    checks++; if ({DONE, PASS, FAIL} !== 3'b101) begin errors++; $display("FAIL flip_hold_verdict got %b exp 101", {DONE, PASS, FAIL}); end
    EN = 1'b0; FINISH = 1'b0; DATA_IN = 16'h0000;
  endtask

  task automatic test_shift_feedback();
    START = 1'b0;
    step();
    checks++; if (FAIL !== 1'b1) begin errors++; $display("FAIL fb_start_low_hold got %b exp 1", FAIL); end
    START = 1'b1;
    step();
    checks++; if ({DONE, PASS, FAIL} !== 3'b000) begin errors++; $display("FAIL fb_rise_clear got %b exp 000", {DONE, PASS, FAIL}); end
    checks++; if (SIGNATURE !== 16'h0000) begin errors++; $display("FAIL fb_reload got %h exp 0000", SIGNATURE); end
    checks++; if (VEC_COUNT !== 11'd0) begin errors++; $display("FAIL fb_count_clear got %0d exp 0", VEC_COUNT); end
    EN = 1'b1; DATA_IN = 16'h0001;
    step();
    checks++; if (SIGNATURE !== 16'h0001) begin errors++; $display("FAIL fb_sig1 got %h exp 0001", SIGNATURE); end
    DATA_IN = 16'h0000;
    step();
    checks++; if (SIGNATURE !== 16'h0002) begin errors++; $display("FAIL fb_sig2 got %h exp 0002", SIGNATURE); end
    repeat (14) step();
    checks++; if (SIGNATURE !== 16'h8000) begin errors++; $display("FAIL fb_sig_msb got %h exp 8000", SIGNATURE); end
    step();
    checks++; if (SIGNATURE !== 16'h1021) begin errors++; $display("FAIL fb_feedback got %h exp 1021", SIGNATURE); end
    checks++; if (VEC_COUNT !== 11'd17) begin errors++; $display("FAIL fb_count got %0d exp 17", VEC_COUNT); end
    EN = 1'b0; FINISH = 1'b1;
    step();
    FINISH = 1'b0;
    step(); step();
    checks++; if ({DONE, PASS, FAIL} !== 3'b101) begin errors++; $display("FAIL fb_verdict got %b exp 101", {DONE, PASS, FAIL}); end
  endtask

  task automatic test_dropped_en();
    open_run();
    EN = 1'b1; DATA_IN = 16'h0000;
    repeat (3) step();
    FINISH = 1'b1;  // EN still high: this vector counts
    step();
    EN = 1'b0; FINISH = 1'b0;
    checks++; if (VEC_COUNT !== 11'd4) begin errors++; $display("FAIL drop_count got %0d exp 4", VEC_COUNT); end
    step(); step();
    checks++; if ({DONE, PASS, FAIL} !== 3'b101) begin errors++; $display("FAIL drop_verdict got %b exp 101", {DONE, PASS, FAIL}); end
  endtask

  task automatic test_en_with_finish();
    open_run();
    EN = 1'b1; DATA_IN = 16'h0000;
    repeat (4) step();
    FINISH = 1'b1;
    step();
    EN = 1'b0; FINISH = 1'b0;
    checks++; if (VEC_COUNT !== 11'd5) begin errors++; $display("FAIL enfin_count got %0d exp 5", VEC_COUNT); end
    step(); step();
    checks++; if ({DONE, PASS, FAIL} !== 3'b110) begin errors++; $display("FAIL enfin_verdict got %b exp 110", {DONE, PASS, FAIL}); end
  endtask

  task automatic test_restart();
    open_run();
    EN = 1'b1; DATA_IN = 16'h0003;
    repeat (2) step();
    START = 1'b0;
    step();
    checks++; if (VEC_COUNT !== 11'd3) begin errors++; $display("FAIL rst_pre_count got %0d exp 3", VEC_COUNT); end
    // Rise together with EN and FINISH: restart wins.
    START = 1'b1; FINISH = 1'b1; DATA_IN = 16'h0001;
    step();
    checks++; if (SIGNATURE !== 16'h0000) begin errors++; $display("FAIL rst_sig got %h exp 0000", SIGNATURE); end
    checks++; if (VEC_COUNT !== 11'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", VEC_COUNT); end
    FINISH = 1'b0; DATA_IN = 16'h0000;
    step();
    EN = 1'b0;
    step(); step();
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL rst_no_compare got %b exp 0", DONE); end
    checks++; if (VEC_COUNT !== 11'd1) begin errors++; $display("FAIL rst_still_compact got %0d exp 1", VEC_COUNT); end
    EN = 1'b1;
    repeat (4) step();
    EN = 1'b0; FINISH = 1'b1;
    step();
    FINISH = 1'b0;
    step(); step();
    checks++; if ({DONE, PASS, FAIL} !== 3'b110) begin errors++; $display("FAIL rst_verdict got %b exp 110", {DONE, PASS, FAIL}); end
  endtask

  task automatic test_reset_mid();
    open_run();
    EN = 1'b1; DATA_IN = 16'h0000;
    repeat (299) step();
    DATA_IN = 16'h0001;
    step();
    checks++; if (VEC_COUNT !== 11'd300) begin errors++; $display("FAIL mid_count got %0d exp 300", VEC_COUNT); end
    checks++; if (SIGNATURE !== 16'h0001) begin errors++; $display("FAIL mid_sig got %h exp 0001", SIGNATURE); end
    #2 RESET = 1'b0;
    #1;
    checks++; if (SIGNATURE !== 16'h0000) begin errors++; $display("FAIL mid_async_sig got %h exp 0000", SIGNATURE); end
    checks++; if (VEC_COUNT !== 11'd0) begin errors++; $display("FAIL mid_async_count got %0d exp 0", VEC_COUNT); end
    checks++; if ({DONE, PASS, FAIL} !== 3'b000) begin errors++; $display("FAIL mid_async_verdict got %b exp 000", {DONE, PASS, FAIL}); end
    step();
    RESET = 1'b1;
    repeat (2) step();
    checks++; if (VEC_COUNT !== 11'd0) begin errors++; $display("FAIL mid_no_run got %0d exp 0", VEC_COUNT); end
    open_run();
    EN = 1'b1; DATA_IN = 16'h0000;
    repeat (5) step();
    EN = 1'b0; FINISH = 1'b1;
    step();
    FINISH = 1'b0;
    step(); step();
    checks++; if ({DONE, PASS, FAIL} !== 3'b110) begin errors++; $display("FAIL mid_fresh_verdict got %b exp 110", {DONE, PASS, FAIL}); end
  endtask

  task automatic test_saturation();
    open_run();
    EN = 1'b1; DATA_IN = 16'h0000;
    repeat (2047) step();
    checks++; if (VEC_COUNT !== 11'd2047) begin errors++; $display("FAIL sat_reach got %0d exp 2047", VEC_COUNT); end
    repeat (3) step();
    checks++; if (VEC_COUNT !== 11'd2047) begin errors++; $display("FAIL sat_hold got %0d exp 2047", VEC_COUNT); end
    EN = 1'b0; FINISH = 1'b1;
    step();
    FINISH = 1'b0;
    step(); step();
    checks++; if ({DONE, PASS, FAIL} !== 3'b101) begin errors++; $display("FAIL sat_verdict got %b exp 101", {DONE, PASS, FAIL}); end
  endtask

  initial begin
    test_reset();
    test_zero_pass();
    test_fail_flip();
    test_shift_feedback();
    test_dropped_en();
    test_en_with_finish();
    test_restart();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
